// File: rtl/scrambler_ctrl_64b66b.sv
// 64b/66b transmit scrambler controller: x^58+x^39+1 payload scrambler,
// header passthrough, valid/ready in and out, invalid-header counter.
// Ports: CLK, rst (async high); s_valid/s_ready/s_data/s_header in;
// m_valid/m_ready/m_data out; scr_enable; err_cnt, hdr_err status.
// Optional SCR_SEED_LOAD_EN adds seed_load/seed and the RESEED state.
module scrambler_ctrl_64b66b #(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  input  logic [1:0]       s_header,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [65:0]      m_data,
  input  logic             scr_enable,
`ifdef SCR_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [57:0]      seed,
`endif
  output logic [ERR_W-1:0] err_cnt,
  output logic             hdr_err
);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    RESEED
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t      state;
  logic [57:0] scr_s;
  logic        legal;
  logic        do_scr;
  logic        accept;
  logic [63:0] y;

  // History h[57:0] is the state (h[57] newest); each scrambled bit
  // extends it, so y[n] = d[n] ^ h[n+19] ^ h[n].
  function automatic logic [63:0] scramble(
    input logic [63:0] d,
    input logic [57:0] s
  );
    logic [121:0] h;
    h = '0;
    h[57:0] = s;
    for (int n = 0; n < 64; n++)
      h[58+n] = d[n] ^ h[n+19] ^ h[n];
    return h[121:58];
  endfunction

  always_comb begin
    legal  = ^s_header;
    do_scr = scr_enable && legal;
    y      = scramble(s_data, scr_s);
`ifdef SCR_SEED_LOAD_EN
    // A reseed request blocks acceptance in the same cycle.
    s_ready = (state == RUN) && (!m_valid || m_ready) && !seed_load;
`else
    s_ready = (state == RUN) && (!m_valid || m_ready);
`endif
    accept = s_valid && s_ready;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      scr_s   <= '1;
      m_valid <= 1'b0;
      m_data  <= '0;
      hdr_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        INIT: state <= RUN;
        RUN: begin
`ifdef SCR_SEED_LOAD_EN
          if (seed_load) begin
            scr_s <= seed;
            state <= RESEED;
          end
`endif
        end
        RESEED: state <= RUN;
        default: state <= INIT;
      endcase
      if (accept) begin
        m_valid <= 1'b1;
        hdr_err <= !legal;
        if (do_scr) begin
          m_data <= {y, s_header};
          scr_s  <= y[63:6];
        end else begin
          m_data <= {s_data, s_header};
        end
        if (!legal && err_cnt != ERR_MAX)
          err_cnt <= err_cnt + 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scrambler_ctrl_64b66b.sv
// Scoreboard bench for scrambler_ctrl_64b66b with a bit-serial
// reference scrambler; inputs change on negedge, sampled 1ns pre-edge.
module tb_scrambler_ctrl_64b66b;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic [1:0]  s_header = 2'b01;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [65:0] m_data;
  logic        scr_enable = 1'b1;
  logic        seed_load = 1'b0;
  logic [57:0] seed = '0;
  logic [7:0]  err_cnt;
  logic        hdr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [66:0] sb[$];
  logic [57:0] ms = '1;
  int          errm = 0;

  always #5 CLK = ~CLK;

  scrambler_ctrl_64b66b #(.ERR_W(8)) dut (
    .CLK(CLK),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_header(s_header),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .scr_enable(scr_enable),
`ifdef SCR_SEED_LOAD_EN
    .seed_load(seed_load),
    .seed(seed),
`endif
    .err_cnt(err_cnt),
    .hdr_err(hdr_err)
  );

  task automatic chk(input string tag,
                     input logic [65:0] obs,
                     input logic [65:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [66:0] model(input logic [63:0] d,
                                        input logic [1:0] h,
                                        input logic en);
    logic [63:0] yv;
    logic        b;
    logic        bad;
    bad = (h == 2'b00) || (h == 2'b11);
    yv = d;
    if (en && !bad) begin
      for (int n = 0; n < 64; n++) begin
        b = d[n] ^ ms[19] ^ ms[0];
        yv[n] = b;
        ms = {b, ms[57:1]};
      end
    end
    if (bad && errm < 255) errm++;
    return {bad, yv, h};
  endfunction

  task automatic tick(output logic acc);
    logic       tk;
    logic [66:0] e;
    #4;
    acc = s_valid && s_ready;
    tk = m_valid && m_ready;
    if (tk) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 66'(m_valid), 66'd0);
      end else begin
        e = sb.pop_front();
        chk("m_data", m_data, e[65:0]);
        chk("hdr_err", 66'(hdr_err), 66'(e[66]));
      end
    end
    if (acc) sb.push_back(model(s_data, s_header, scr_enable));
    @(negedge CLK);
  endtask

  task automatic send(input logic [63:0] d, input logic [1:0] h,
                      input logic en, output int cyc);
    logic a;
    s_valid = 1'b1;
    s_data = d;
    s_header = h;
    scr_enable = en;
    cyc = 0;
    a = 1'b0;
    while (!a && cyc < 20) begin
      tick(a);
      cyc++;
    end
    if (!a) chk("send_timeout", 66'(cyc), 66'd0);
  endtask

  task automatic drain();
    logic a;
    int   k;
    s_valid = 1'b0;
    k = 0;
    while ((sb.size() != 0 || m_valid) && k < 40) begin
      tick(a);
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 66'(sb.size()), 66'd0);
  endtask

  initial begin
    int          c;
    logic        a;
    logic [65:0] held;
    logic [1:0]  hv;

    #1;
    chk("rst_m_valid", 66'(m_valid), 66'd0);
    chk("rst_m_data", m_data, 66'd0);
    chk("rst_err_cnt", 66'(err_cnt), 66'd0);
    chk("rst_hdr_err", 66'(hdr_err), 66'd0);
    chk("rst_s_ready", 66'(s_ready), 66'd0);
    @(negedge CLK);
    rst = 1'b0;

    // INIT cycle then first accept
    s_valid = 1'b1;
    #4;
    chk("init_s_ready", 66'(s_ready), 66'd0);
    @(negedge CLK);
    send(64'd0, 2'b01, 1'b1, c);
    chk("first_accept_cyc", 66'(c), 66'd1);
    chk("lat_m_valid", 66'(m_valid), 66'd1);
    chk("first_hdr", 66'(m_data[1:0]), 66'd1);
    chk("first_low", 66'(m_data[40:2]), 66'd0);
    for (int i = 0; i < 15; i++) begin
      hv = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      send({$urandom, $urandom}, hv, 1'b1, c);
      chk("b2b_cyc", 66'(c), 66'd1);
    end
    drain();

    // pass-through then scrambled with unchanged state
    send(64'hDEADBEEF_01234567, 2'b10, 1'b0, c);
    chk("bypass_word", m_data, {64'hDEADBEEF_01234567, 2'b10});
    send(64'h0123_4567_89AB_CDEF, 2'b01, 1'b1, c);
    drain();

    // illegal headers: saturating counter
    for (int i = 0; i < 300; i++) begin
      send({$urandom, $urandom}, 2'b11, 1'b1, c);
      if (i == 9) begin
        drain();
        chk("err_cnt_10", 66'(err_cnt), 66'd10);
      end
    end
    drain();
    chk("err_cnt_sat", 66'(err_cnt), 66'(errm));
    chk("err_cnt_255", 66'(err_cnt), 66'd255);
    send(64'h5555, 2'b00, 1'b1, c);
    send(64'h1234, 2'b01, 1'b1, c);
    drain();
    chk("err_cnt_hold", 66'(err_cnt), 66'd255);

    // backpressure
    m_ready = 1'b0;
    send(64'hA5A5_A5A5_0000_1111, 2'b01, 1'b1, c);
    held = sb[0][65:0];
    s_data = 64'hB0B0_B0B0_2222_3333;
    s_header = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("stall_s_ready", 66'(s_ready), 66'd0);
      chk("stall_m_data", m_data, held);
      chk("stall_m_valid", 66'(m_valid), 66'd1);
      @(negedge CLK);
    end
    m_ready = 1'b1;
    send(64'hB0B0_B0B0_2222_3333, 2'b10, 1'b1, c);
    chk("release_cyc", 66'(c), 66'd1);
    send(64'hC0C0_C0C0_4444_5555, 2'b01, 1'b1, c);
    chk("release_cyc2", 66'(c), 66'd1);
    drain();

`ifdef SCR_SEED_LOAD_EN
    s_valid = 1'b1;
    s_data = 64'hFFFF;
    s_header = 2'b01;
    seed_load = 1'b1;
    seed = '0;
    tick(a);
    chk("seed_no_accept", 66'(a), 66'd0);
    seed_load = 1'b0;
    ms = '0;
    for (int i = 0; i < 3; i++) begin
      send(64'd0, 2'b01, 1'b1, c);
      chk("seed_zero_out", 66'(m_data[65:2]), 66'd0);
    end
    drain();
`endif

    // asynchronous reset mid-stream
    send(64'h1111_2222_3333_4444, 2'b01, 1'b1, c);
    send(64'h5555_6666_7777_8888, 2'b10, 1'b1, c);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 66'(m_valid), 66'd0);
    chk("arst_m_data", m_data, 66'd0);
    chk("arst_s_ready", 66'(s_ready), 66'd0);
    sb.delete();
    ms = '1;
    errm = 0;
    @(negedge CLK);
    rst = 1'b0;
    chk("arst_err_cnt", 66'(err_cnt), 66'd0);
    send(64'd0, 2'b01, 1'b1, c);
    chk("arst_init_cyc", 66'(c), 66'd2);
    send(64'hFEDC_BA98_7654_3210, 2'b10, 1'b1, c);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
